// File: rtl/tile_reduction_engine.sv
// Tile reduction engine: column-reduces per-array result tiles and accumulates them over beat groups.
// Latency: a closed group's result reaches the FIFO head on the cycle after the closing beat handshake.
// Backpressure: in_ready drops while the result FIFO is full, except in a cycle where the head is popped.
module tile_reduction_engine #(
  parameter int TILE_SIZE  = 4,
  parameter int NUM_ARRAYS = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_BEATS  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic signed [ACC_WIDTH-1:0] mat_in [NUM_ARRAYS][TILE_SIZE][TILE_SIZE],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_vec [TILE_SIZE],
  output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
  output logic                        out_sat
);

  // Accumulators are wide enough that a full group of worst-case beats cannot wrap.
  localparam int SUM_W = ACC_WIDTH + $clog2(NUM_ARRAYS * TILE_SIZE * MAX_BEATS);
  localparam int BW    = $clog2(MAX_BEATS + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {OP_VEC = 2'd0, OP_OUTER = 2'd1, OP_PASS = 2'd2} op_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_e;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [ACC_WIDTH-1:0] v);
    sext = {{(SUM_W-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
  endfunction

  state_e                  r_state;
  state_e                  w_state_nxt;
  op_e                     r_mode;
  op_e                     w_mode_dec;
  op_e                     w_op;
  logic                    r_rdy_en;
  logic signed [SUM_W-1:0] r_acc [TILE_SIZE];
  logic [BW-1:0]           r_beats;

  logic signed [SUM_W-1:0]     w_colsum  [NUM_ARRAYS][TILE_SIZE];
  logic signed [SUM_W-1:0]     w_acc_nxt [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] w_sat_vec [TILE_SIZE];
  logic                        w_sat_any;
  logic [BW-1:0]               w_beats_inc;
  logic                        w_accept;
  logic                        w_close;
  logic                        w_pop;
  logic                        w_head_vld;

  logic signed [ACC_WIDTH-1:0] r_fifo_vec   [FIFO_DEPTH][TILE_SIZE];
  logic [BW-1:0]               r_fifo_beats [FIFO_DEPTH];
  logic                        r_fifo_sat   [FIFO_DEPTH];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;

  // r_rdy_en keeps in_ready low through reset and opens it on the first edge after release.
  assign w_head_vld = (r_count != '0);
  assign w_pop      = w_head_vld && out_ready;
  assign in_ready   = r_rdy_en && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = w_head_vld;

  // Decode the raw mode bus into the three operations.
  always_comb begin
    w_mode_dec = OP_PASS;
    case (mode)
      3'b000, 3'b010, 3'b100: w_mode_dec = OP_VEC;
      3'b011:                 w_mode_dec = OP_OUTER;
      default:                w_mode_dec = OP_PASS;
    endcase
  end

  // The first beat of a group uses the live mode; later beats use the latched one.
  always_comb begin
    w_op = (r_state == ST_IDLE) ? w_mode_dec : r_mode;
  end

  // Column sums of every array tile, sign-extended to accumulator width.
  always_comb begin
    for (int k = 0; k < NUM_ARRAYS; k++) begin
      for (int j = 0; j < TILE_SIZE; j++) begin
        w_colsum[k][j] = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
          w_colsum[k][j] = w_colsum[k][j] + sext(mat_in[k][i][j]);
        end
      end
    end
  end

  // Per-lane contribution of this beat added onto the running accumulators.
  always_comb begin
    logic signed [SUM_W-1:0] v_add;
    v_add = '0;
    for (int j = 0; j < TILE_SIZE; j++) begin
      v_add = '0;
      case (w_op)
        OP_VEC:   v_add = w_colsum[NUM_ARRAYS-1][j];
        OP_OUTER: begin
          for (int k = 0; k < NUM_ARRAYS; k++) begin
            v_add = v_add + w_colsum[k][j];
          end
        end
        default:  v_add = w_colsum[0][j];
      endcase
      w_acc_nxt[j] = r_acc[j] + v_add;
    end
  end

  // Clamp each lane to the output range and flag any clamped lane.
  always_comb begin
    w_sat_any = 1'b0;
    for (int j = 0; j < TILE_SIZE; j++) begin
      w_sat_vec[j] = w_acc_nxt[j][ACC_WIDTH-1:0];
      if (w_acc_nxt[j] > SAT_MAX) begin
        w_sat_vec[j] = SAT_MAX[ACC_WIDTH-1:0];
        w_sat_any    = 1'b1;
      end else if (w_acc_nxt[j] < SAT_MIN) begin
        w_sat_vec[j] = SAT_MIN[ACC_WIDTH-1:0];
        w_sat_any    = 1'b1;
      end
    end
  end

  // Group FSM next state: a beat closes on in_last, in PASS, or on reaching MAX_BEATS.
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    w_beats_inc = r_beats + 1'b1;
    if (w_accept) begin
      w_close = in_last || (w_op == OP_PASS) || (w_beats_inc == BW'(MAX_BEATS));
      case (r_state)
        ST_IDLE:  w_state_nxt = w_close ? ST_IDLE : ST_ACCUM;
        ST_ACCUM: w_state_nxt = w_close ? ST_IDLE : ST_ACCUM;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Group FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Input-ready enable opens one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  // Accumulators, beat counter and latched mode; cleared when a group closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < TILE_SIZE; j++) r_acc[j] <= '0;
      r_beats <= '0;
      r_mode  <= OP_VEC;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) r_mode <= w_mode_dec;
      if (w_close) begin
        for (int j = 0; j < TILE_SIZE; j++) r_acc[j] <= '0;
        r_beats <= '0;
      end else begin
        for (int j = 0; j < TILE_SIZE; j++) r_acc[j] <= w_acc_nxt[j];
        r_beats <= w_beats_inc;
      end
    end
  end

  // Result FIFO: push on group close, pop on out handshake, both allowed when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        for (int j = 0; j < TILE_SIZE; j++) r_fifo_vec[e][j] <= '0;
        r_fifo_beats[e] <= '0;
        r_fifo_sat[e]   <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_close) begin
        for (int j = 0; j < TILE_SIZE; j++) r_fifo_vec[r_wr_ptr][j] <= w_sat_vec[j];
        r_fifo_beats[r_wr_ptr] <= w_beats_inc;
        r_fifo_sat[r_wr_ptr]   <= w_sat_any;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_close, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Present the FIFO head; outputs read as zero whenever the FIFO is empty.
  always_comb begin
    out_beats = '0;
    out_sat   = 1'b0;
    for (int j = 0; j < TILE_SIZE; j++) out_vec[j] = '0;
    if (w_head_vld) begin
      for (int j = 0; j < TILE_SIZE; j++) out_vec[j] = r_fifo_vec[r_rd_ptr][j];
      out_beats = r_fifo_beats[r_rd_ptr];
      out_sat   = r_fifo_sat[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_tile_reduction_engine.sv
// Directed bench for tile_reduction_engine with default parameters.
// Inputs are driven and outputs sampled 1-2 time units after the rising edge.
// Every wait on the DUT is bounded and an expired bound is reported as a failed check.
module tb_tile_reduction_engine;

  logic              clk;
  logic              rst_n;
  logic [2:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic signed [31:0] mat_in [4][4][4];
  logic              out_valid;
  logic              out_ready;
  logic signed [31:0] out_vec [4];
  logic [4:0]        out_beats;
  logic              out_sat;

  int checks = 0;
  int errors = 0;

  tile_reduction_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .mat_in    (mat_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_beats (out_beats),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_array(input int k, input logic signed [31:0] v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat_in[k][i][j] = v;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) set_array(k, 32'sd0);
  endtask

  // Array 0 element [i][j] = 10*i + j + n, so its column sum is 60 + 4*j + 4*n.
  task automatic set_pass(input int n);
    for (int k = 1; k < 4; k++) set_array(k, 32'sd100);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat_in[0][i][j] = 10 * i + j + n;
  endtask

  task automatic beat(input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_last  = last;
    #1;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3,
                           input logic [31:0] eb, input logic [31:0] es);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".lane0"}, out_vec[0], e0);
    chk({tag, ".lane1"}, out_vec[1], e1);
    chk({tag, ".lane2"}, out_vec[2], e2);
    chk({tag, ".lane3"}, out_vec[3], e3);
    chk({tag, ".beats"}, 32'(out_beats), eb);
    chk({tag, ".sat"},   32'(out_sat), es);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 3'b000;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    clear_all();

    // Reset state.
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_vec0",  out_vec[0],     32'd0);
    chk("rst.out_beats", 32'(out_beats), 32'd0);
    chk("rst.out_sat",   32'(out_sat),   32'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("rel.in_ready_before_edge", 32'(in_ready), 32'd1 - 32'd1);
    @(posedge clk); #1;
    chk("rel.in_ready_after_edge", 32'(in_ready), 32'd1);

    // VEC, 3 beats of array3 = 1; mode flips to OUTER mid-group and must be ignored.
    for (int k = 0; k < 3; k++) set_array(k, 32'sd7);
    set_array(3, 32'sd1);
    mode = 3'b000;
    beat(1'b0);
    mode = 3'b011;
    beat(1'b0);
    chk("vec.no_early_result", 32'(out_valid), 32'd0);
    beat(1'b1);
    chk("vec.latency", 32'(out_valid), 32'd1);
    pop_check("vec", 32'd12, 32'd12, 32'd12, 32'd12, 32'd3, 32'd0);

    // OUTER, array k = k+1, single closing beat: 4+8+12+16 = 40.
    for (int k = 0; k < 4; k++) set_array(k, 32'(k + 1));
    mode = 3'b011;
    chk("outer.idle", 32'(out_valid), 32'd0);
    beat(1'b1);
    chk("outer.latency", 32'(out_valid), 32'd1);
    pop_check("outer", 32'd40, 32'd40, 32'd40, 32'd40, 32'd1, 32'd0);

    // Forced close at MAX_BEATS, then a one-beat group.
    clear_all();
    set_array(3, 32'sd1);
    mode = 3'b100;
    for (int b = 0; b < 16; b++) begin
      beat(1'b0);
      if (b == 14) chk("force.no_result_at_15", 32'(out_valid), 32'd0);
    end
    chk("force.result_at_16", 32'(out_valid), 32'd1);
    beat(1'b1);
    pop_check("force.first",  32'd64, 32'd64, 32'd64, 32'd64, 32'd16, 32'd0);
    pop_check("force.second", 32'd4,  32'd4,  32'd4,  32'd4,  32'd1,  32'd0);
    chk("force.drained", 32'(out_valid), 32'd0);

    // Positive and negative saturation, then the exact maximum without saturation.
    mode = 3'b010;
    set_array(3, 32'sh2000_0000);
    beat(1'b0);
    beat(1'b1);
    pop_check("sat.pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd2, 32'd1);
    set_array(3, 32'shE000_0000);
    beat(1'b0);
    beat(1'b1);
    pop_check("sat.neg", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd1);
    set_array(3, 32'sh2000_0000);
    for (int j = 0; j < 4; j++) mat_in[3][3][j] = 32'sh1FFF_FFFF;
    beat(1'b1);
    pop_check("sat.edge", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0);

    // PASS with a stalled consumer: FIFO fills, third beat enters on the pop cycle.
    mode = 3'b111;
    set_pass(0);
    beat(1'b0);
    chk("pass.first_visible", 32'(out_valid), 32'd1);
    set_pass(1);
    beat(1'b0);
    chk("pass.full_blocks", 32'(in_ready), 32'd0);
    set_pass(2);
    in_valid = 1'b1;
    in_last  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pass.still_blocked", 32'(in_ready),  32'd0);
    chk("pass.hold.lane0",    out_vec[0],     32'd60);
    chk("pass.hold.lane3",    out_vec[3],     32'd72);
    chk("pass.hold.beats",    32'(out_beats), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("pass.ready_on_pop", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pass.second.lane0", out_vec[0], 32'd64);
    chk("pass.second.lane3", out_vec[3], 32'd76);
    @(posedge clk); #1;
    chk("pass.third.valid", 32'(out_valid), 32'd1);
    chk("pass.third.lane0", out_vec[0], 32'd68);
    chk("pass.third.lane3", out_vec[3], 32'd80);
    chk("pass.third.beats", 32'(out_beats), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pass.drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a group discards it; only the fresh group emerges.
    clear_all();
    set_array(3, 32'sd1);
    mode = 3'b000;
    beat(1'b0);
    beat(1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    chk("midrst.held", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.ready_after", 32'(in_ready), 32'd1);
    set_array(3, 32'sd2);
    beat(1'b1);
    pop_check("midrst.fresh", 32'd8, 32'd8, 32'd8, 32'd8, 32'd1, 32'd0);
    chk("midrst.only_one", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
